wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Shares the single register-file write port between two write-back sources: ALU results (register ops) and memory load returns.
- Each source has a small FIFO, and a fixed-priority arbiter with anti-starvation drains both FIFOs into a registered write port.
- The write port drives the rd port of the register file.
- A pending-write mask is exported so the decode stage can stall on RAW hazards against queued writes.

Parameters:
- XLEN, 32, data width (matches cXLEN).
- REG_AW, 5, register address width.
- FIFO_DEPTH, 2, entries per source FIFO; power of two, minimum 2.
- STARVE_LIMIT, 4, consecutive ALU losses before the ALU is forced to win.

Ports:
- iClk  in  1  core clock.
- iRst  in  1  asynchronous, active-low reset.
- iAluValid  in  1  ALU write-back request.
- iAluRd  in  REG_AW  ALU destination register.
- iAluData  in  XLEN  ALU result.
- oAluReady  out  1  ALU FIFO can accept.
- iMemValid  in  1  load write-back request.
- iMemRd  in  REG_AW  load destination register.
- iMemData  in  XLEN  load data.
- oMemReady  out  1  memory FIFO can accept.
- oWrEn  out  1  register-file write strobe (registered).
- oWrAddr  out  REG_AW  write address (registered).
- oWrData  out  XLEN  write data (registered).
- oBusyRd  out  2**REG_AW  bit r set while any queued entry targets register r.

Behaviour:
- Clocking and reset: one clock, iClk. Reset iRst is asynchronous and active-low.
- While iRst=0:
  - both FIFOs empty; oWrEn=0, oWrAddr=0, oWrData=0;
  - oBusyRd=0; starvation counter=0;
  - oAluReady=0 and oMemReady=0.
- Ready release: the ready outputs come from a registered reset-done flag and go to 1 on the first clock edge after iRst rises.
- Handshake: a transfer happens when valid & ready at a rising edge. ready = reset-done & FIFO not full.
  - Valid may be held while ready=0; data must then stay stable.
  - ready does not depend on the other source.
- x0 filter: a transfer with rd=0 is accepted but not stored. It never produces oWrEn and never sets a busy bit.
- Full FIFO: ready=0 in every cycle the FIFO holds FIFO_DEPTH entries.
  - A pop and a push in the same cycle on a full FIFO is not allowed, because ready is already low.
  - A pop and a push in the same cycle on a non-full FIFO is legal; the count is unchanged.
- Arbitration is evaluated every cycle on the FIFO heads:
  - Only one head non-empty: that head wins.
  - Both heads non-empty: memory wins, unless starveCnt == STARVE_LIMIT, in which case the ALU wins.
  - The winner is popped at the edge, and its rd/data load oWrAddr/oWrData with oWrEn=1 in the next cycle.
  - No winner: oWrEn=0 next cycle; oWrAddr/oWrData hold their last values.
- Starvation counter (width clog2(STARVE_LIMIT+1)):
  - increments when the ALU head is valid and loses;
  - clears when the ALU wins or the ALU FIFO is empty;
  - saturates at STARVE_LIMIT.
- Latency (without the optional feature): an uncontended transfer accepted at edge k appears as oWrEn=1 in the cycle after edge k+1, i.e. 2 cycles.
- Throughput: one write per cycle sustained.
- Ordering:
  - Entries from the same source are written in FIFO order.
  - Across sources there is no age ordering. When both heads target the same rd, the later write follows the grant order (normally memory first, then ALU).
- oBusyRd: combinational OR of one-hot(rd) over all valid FIFO entries of both sources. The entry in the output register is not included.
- Reset mid-operation: all queued entries are discarded, with no partial write; outputs return to reset values immediately.

Optional Feature:
- Macro: WB_BYPASS_EN.
- When defined, a source whose FIFO is empty competes with its incoming transfer, under the same arbitration rules.
  - If that transfer wins, it goes straight to the output register and is not stored; oWrEn rises 1 cycle after acceptance.
  - If it loses, it is stored in the FIFO as normal.
  - A bypassed entry never sets oBusyRd.
- When undefined: the 2-cycle path described under Behaviour, with no combinational path from the inputs to the write-port registers.

Test Plan:
- Reset release: assert iRst=0 mid-traffic with 2 ALU entries queued → oWrEn=0, oBusyRd=0 immediately; ready=0 until the first edge after iRst=1, then 1; no write of the discarded entries.
- Single source: ALU sends rd=5 data=0xDEADBEEF → oWrEn=1, oWrAddr=5, oWrData=0xDEADBEEF exactly 2 cycles after the accept (1 cycle with WB_BYPASS_EN); oBusyRd[5]=1 only while queued.
- Contention: both sources valid every cycle, mem rd=1..8, ALU rd=9..16 → memory written 4 times, then one ALU write, repeating (STARVE_LIMIT=4); no entry lost; write order per source preserved.
- Back-pressure: hold mem valid with the ALU FIFO draining continuously → memory FIFO fills to 2, oMemReady=0, input held stable; ready reasserts the cycle after a pop; 3rd entry is written once, intact.
- x0 filter: ALU sends rd=0 data=0x1234 → accepted (ready stays 1), no oWrEn ever, oBusyRd stays 0.
- Same-rd collision: ALU and memory both push rd=7 in the same cycle (ALU 0xA, memory 0xB) → two writes, 0xB then 0xA; oBusyRd[7] clears after the second pop.

Source files
------------

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
//
// Purpose:
//   Shares the single register-file write port between two write-back
//   sources: ALU results and memory load returns. Each source feeds a small
//   FIFO. A fixed-priority arbiter (memory first) with an ALU anti-starvation
//   counter drains both FIFOs into a registered write port. A pending-write
//   mask (oBusyRd) lets decode stall on RAW hazards against queued writes.
//
// Optional feature (macro WB_BYPASS_EN):
//   When defined, a source whose FIFO is empty competes with its incoming
//   transfer. A winning transfer goes straight to the write-port registers
//   (1-cycle latency) and is never stored. A losing transfer is queued as
//   normal. When undefined, every write goes through a FIFO (2-cycle latency)
//   and there is no combinational path from the inputs to the write port.
//
// Ports:
//   iClk, iRst                    clock, asynchronous active-low reset
//   iAluValid/iAluRd/iAluData     ALU write-back request
//   oAluReady                     ALU FIFO can accept
//   iMemValid/iMemRd/iMemData     load write-back request
//   oMemReady                     memory FIFO can accept
//   oWrEn/oWrAddr/oWrData         registered register-file write port
//   oBusyRd                       bit r set while a queued entry targets r
// -----------------------------------------------------------------------------
module wb_arbiter #(
    parameter int XLEN         = 32,
    parameter int REG_AW       = 5,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic                 iAluValid,
    input  logic [REG_AW-1:0]    iAluRd,
    input  logic [XLEN-1:0]      iAluData,
    output logic                 oAluReady,
    input  logic                 iMemValid,
    input  logic [REG_AW-1:0]    iMemRd,
    input  logic [XLEN-1:0]      iMemData,
    output logic                 oMemReady,
    output logic                 oWrEn,
    output logic [REG_AW-1:0]    oWrAddr,
    output logic [XLEN-1:0]      oWrData,
    output logic [2**REG_AW-1:0] oBusyRd
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [CW-1:0] FULL_CNT   = CW'(FIFO_DEPTH);

    logic                  rst_done;

    logic [REG_AW-1:0]     alu_rd_q   [FIFO_DEPTH];
    logic [XLEN-1:0]       alu_data_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] alu_vld;
    logic [AW-1:0]         alu_rptr, alu_wptr;
    logic [CW-1:0]         alu_cnt;

    logic [REG_AW-1:0]     mem_rd_q   [FIFO_DEPTH];
    logic [XLEN-1:0]       mem_data_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] mem_vld;
    logic [AW-1:0]         mem_rptr, mem_wptr;
    logic [CW-1:0]         mem_cnt;

    logic [SW-1:0]         starve_cnt;

    logic                  alu_empty, alu_full, alu_acc, alu_push, alu_pop;
    logic                  mem_empty, mem_full, mem_acc, mem_push, mem_pop;
    logic                  alu_cand, mem_cand, alu_win, mem_win, starved;
    logic [REG_AW-1:0]     alu_c_rd, mem_c_rd;
    logic [XLEN-1:0]       alu_c_data, mem_c_data;
    logic [2**REG_AW-1:0]  busy;

    assign alu_empty = (alu_cnt == '0);
    assign alu_full  = (alu_cnt == FULL_CNT);
    assign mem_empty = (mem_cnt == '0);
    assign mem_full  = (mem_cnt == FULL_CNT);

    // Ready never depends on the other source, only on reset-done and fullness.
    assign oAluReady = rst_done & ~alu_full;
    assign oMemReady = rst_done & ~mem_full;

    // Writes to x0 are accepted by the handshake but never enter the datapath.
    assign alu_acc = iAluValid & oAluReady & (iAluRd != '0);
    assign mem_acc = iMemValid & oMemReady & (iMemRd != '0);

    // Candidates are the FIFO heads; with bypass an empty FIFO offers its
    // incoming transfer instead. Memory wins ties unless the ALU is starved.
    always_comb begin
        alu_cand   = ~alu_empty;
        alu_c_rd   = alu_rd_q[alu_rptr];
        alu_c_data = alu_data_q[alu_rptr];
        mem_cand   = ~mem_empty;
        mem_c_rd   = mem_rd_q[mem_rptr];
        mem_c_data = mem_data_q[mem_rptr];
`ifdef WB_BYPASS_EN
        if (alu_empty) begin
            alu_cand   = alu_acc;
            alu_c_rd   = iAluRd;
            alu_c_data = iAluData;
        end
        if (mem_empty) begin
            mem_cand   = mem_acc;
            mem_c_rd   = iMemRd;
            mem_c_data = iMemData;
        end
`endif
        starved = (starve_cnt == STARVE_MAX);
        alu_win = alu_cand & (~mem_cand | starved);
        mem_win = mem_cand & ~alu_win;
    end

    // A winning candidate from an empty FIFO is a bypass and is never stored.
    assign alu_push = alu_acc & ~(alu_win & alu_empty);
    assign alu_pop  = alu_win & ~alu_empty;
    assign mem_push = mem_acc & ~(mem_win & mem_empty);
    assign mem_pop  = mem_win & ~mem_empty;

    // Reset-done flag releases both ready outputs one edge after reset lifts.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) rst_done <= 1'b0;
        else       rst_done <= 1'b1;
    end

    // ALU FIFO control; per-entry valid bits feed the busy mask directly.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            alu_rptr <= '0;
            alu_wptr <= '0;
            alu_cnt  <= '0;
            alu_vld  <= '0;
        end else begin
            if (alu_pop) begin
                alu_rptr          <= alu_rptr + 1'b1;
                alu_vld[alu_rptr] <= 1'b0;
            end
            if (alu_push) begin
                alu_wptr          <= alu_wptr + 1'b1;
                alu_vld[alu_wptr] <= 1'b1;
            end
            alu_cnt <= alu_cnt + CW'(alu_push) - CW'(alu_pop);
        end
    end

    // Memory FIFO control, mirror of the ALU side.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            mem_rptr <= '0;
            mem_wptr <= '0;
            mem_cnt  <= '0;
            mem_vld  <= '0;
        end else begin
            if (mem_pop) begin
                mem_rptr          <= mem_rptr + 1'b1;
                mem_vld[mem_rptr] <= 1'b0;
            end
            if (mem_push) begin
                mem_wptr          <= mem_wptr + 1'b1;
                mem_vld[mem_wptr] <= 1'b1;
            end
            mem_cnt <= mem_cnt + CW'(mem_push) - CW'(mem_pop);
        end
    end

    // FIFO storage needs no reset: entries are qualified by the valid bits.
    always_ff @(posedge iClk) begin
        if (alu_push) begin
            alu_rd_q[alu_wptr]   <= iAluRd;
            alu_data_q[alu_wptr] <= iAluData;
        end
        if (mem_push) begin
            mem_rd_q[mem_wptr]   <= iMemRd;
            mem_data_q[mem_wptr] <= iMemData;
        end
    end

    // Counts consecutive ALU losses; any cycle without an ALU loss clears it.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            starve_cnt <= '0;
        end else if (alu_cand && mem_win) begin
            if (!starved) starve_cnt <= starve_cnt + 1'b1;
        end else begin
            starve_cnt <= '0;
        end
    end

    // Registered write port; address and data hold when nothing wins.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            oWrEn   <= 1'b0;
            oWrAddr <= '0;
            oWrData <= '0;
        end else if (alu_win) begin
            oWrEn   <= 1'b1;
            oWrAddr <= alu_c_rd;
            oWrData <= alu_c_data;
        end else if (mem_win) begin
            oWrEn   <= 1'b1;
            oWrAddr <= mem_c_rd;
            oWrData <= mem_c_data;
        end else begin
            oWrEn   <= 1'b0;
        end
    end

    // Busy mask covers queued entries only, not the write-port register.
    always_comb begin
        busy = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (alu_vld[i]) busy[alu_rd_q[i]] = 1'b1;
            if (mem_vld[i]) busy[mem_rd_q[i]] = 1'b1;
        end
    end

    assign oBusyRd = busy;

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter
//
// Purpose:
//   Self-checking bench for wb_arbiter in its default build (WB_BYPASS_EN
//   undefined). Accepted transfers are pushed to per-source expected queues;
//   every write seen on the port is logged and matched against them.
// -----------------------------------------------------------------------------
module tb_wb_arbiter;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int NREG   = 2**REG_AW;

    typedef logic [REG_AW+XLEN-1:0] ent_t;

    logic              iClk = 1'b0;
    logic              iRst = 1'b0;
    logic              iAluValid = 1'b0;
    logic [REG_AW-1:0] iAluRd = '0;
    logic [XLEN-1:0]   iAluData = '0;
    logic              oAluReady;
    logic              iMemValid = 1'b0;
    logic [REG_AW-1:0] iMemRd = '0;
    logic [XLEN-1:0]   iMemData = '0;
    logic              oMemReady;
    logic              oWrEn;
    logic [REG_AW-1:0] oWrAddr;
    logic [XLEN-1:0]   oWrData;
    logic [NREG-1:0]   oBusyRd;

    int   checks   = 0;
    int   failures = 0;
    int   cycle    = 0;
    ent_t exp_alu[$];
    ent_t exp_mem[$];
    ent_t wr_log[$];
    int   wr_cyc[$];

    always #5 iClk = ~iClk;

    wb_arbiter #(
        .XLEN(XLEN), .REG_AW(REG_AW), .FIFO_DEPTH(2), .STARVE_LIMIT(4)
    ) dut (
        .iClk(iClk), .iRst(iRst),
        .iAluValid(iAluValid), .iAluRd(iAluRd), .iAluData(iAluData),
        .oAluReady(oAluReady),
        .iMemValid(iMemValid), .iMemRd(iMemRd), .iMemData(iMemData),
        .oMemReady(oMemReady),
        .oWrEn(oWrEn), .oWrAddr(oWrAddr), .oWrData(oWrData),
        .oBusyRd(oBusyRd)
    );

    // Advance one edge and capture any write present in the following cycle.
    task automatic tick;
        @(posedge iClk);
        #1;
        cycle++;
        if (oWrEn) begin
            wr_log.push_back({oWrAddr, oWrData});
            wr_cyc.push_back(cycle);
        end
    endtask

    task automatic clear_logs;
        wr_log.delete();
        wr_cyc.delete();
        exp_alu.delete();
        exp_mem.delete();
    endtask

    task automatic test_reset;
        iRst = 1'b0;
        tick();
        tick();
        checks++; if (oWrEn !== 1'b0) begin failures++; $display("[TB] FAIL reset_wren got=%b exp=0", oWrEn); end
        checks++; if (oWrAddr !== '0) begin failures++; $display("[TB] FAIL reset_addr got=%0d exp=0", oWrAddr); end
        checks++; if (oWrData !== '0) begin failures++; $display("[TB] FAIL reset_data got=%h exp=0", oWrData); end
        checks++; if (oBusyRd !== '0) begin failures++; $display("[TB] FAIL reset_busy got=%h exp=0", oBusyRd); end
        checks++; if (oAluReady !== 1'b0 || oMemReady !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_ready got=%b%b exp=00", oAluReady, oMemReady);
        end
        @(negedge iClk);
        iRst = 1'b1;
        #1;
        checks++; if (oAluReady !== 1'b0) begin failures++; $display("[TB] FAIL ready_before_edge got=%b exp=0", oAluReady); end
        tick();
        checks++; if (oAluReady !== 1'b1 || oMemReady !== 1'b1) begin
            failures++; $display("[TB] FAIL ready_release got=%b%b exp=11", oAluReady, oMemReady);
        end
        clear_logs();
    endtask

    task automatic test_single;
        iAluValid = 1'b1; iAluRd = 5'd5; iAluData = 32'hDEADBEEF;
        @(negedge iClk);
        checks++; if (oAluReady !== 1'b1) begin failures++; $display("[TB] FAIL single_ready got=%b exp=1", oAluReady); end
        tick();
        exp_alu.push_back({5'd5, 32'hDEADBEEF});
        iAluValid = 1'b0;
        checks++; if (oBusyRd !== 32'h0000_0020) begin failures++; $display("[TB] FAIL single_busy_q got=%h exp=00000020", oBusyRd); end
        checks++; if (oWrEn !== 1'b0) begin failures++; $display("[TB] FAIL single_early got=%b exp=0", oWrEn); end
        tick();
        checks++; if (oWrEn !== 1'b1 || oWrAddr !== 5'd5 || oWrData !== 32'hDEADBEEF) begin
            failures++; $display("[TB] FAIL single_write got=%b/%0d/%h exp=1/5/deadbeef", oWrEn, oWrAddr, oWrData);
        end
        checks++; if (oBusyRd !== '0) begin failures++; $display("[TB] FAIL single_busy_clr got=%h exp=0", oBusyRd); end
        tick();
        checks++; if (oWrEn !== 1'b0) begin failures++; $display("[TB] FAIL single_one_shot got=%b exp=0", oWrEn); end
        checks++; if (wr_log.size() != 1 || wr_log[0] !== exp_alu[0]) begin
            failures++; $display("[TB] FAIL single_sb got_writes=%0d exp=1", wr_log.size());
        end
        clear_logs();
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 4; i++) begin
            iAluValid = 1'b1;
            iAluRd    = REG_AW'(10 + i);
            iAluData  = 32'h1111_1111 * (i + 1);
            @(negedge iClk);
            checks++; if (oAluReady !== 1'b1) begin failures++; $display("[TB] FAIL b2b_ready i=%0d got=%b exp=1", i, oAluReady); end
            tick();
            exp_alu.push_back({iAluRd, iAluData});
        end
        iAluValid = 1'b0;
        repeat (4) tick();
        checks++; if (wr_log.size() != 4) begin
            failures++; $display("[TB] FAIL b2b_count got=%0d exp=4", wr_log.size());
        end else begin
            checks++; if (wr_cyc[3] - wr_cyc[0] != 3) begin
                failures++; $display("[TB] FAIL b2b_throughput got=%0d exp=3", wr_cyc[3] - wr_cyc[0]);
            end
            for (int i = 0; i < 4; i++) begin
                checks++; if (wr_log[i] !== exp_alu[i]) begin
                    failures++; $display("[TB] FAIL b2b_order i=%0d got=%h exp=%h", i, wr_log[i], exp_alu[i]);
                end
            end
        end
        clear_logs();
    endtask

    task automatic test_contention;
        int   mi = 0, ai = 0, mem_low = 0, guard = 0;
        logic mfire, afire;
        ent_t e;
        while ((mi < 8 || ai < 8) && guard < 80) begin
            iMemValid = (mi < 8); iMemRd = REG_AW'(1 + mi); iMemData = 32'h1000_0000 + mi + 1;
            iAluValid = (ai < 8); iAluRd = REG_AW'(9 + ai); iAluData = 32'h2000_0000 + ai + 9;
            @(negedge iClk);
            mfire = iMemValid & oMemReady;
            afire = iAluValid & oAluReady;
            if (iMemValid && !oMemReady) mem_low++;
            tick();
            if (mfire) begin exp_mem.push_back({iMemRd, iMemData}); mi++; end
            if (afire) begin exp_alu.push_back({iAluRd, iAluData}); ai++; end
            guard++;
        end
        iMemValid = 1'b0; iAluValid = 1'b0;
        guard = 0;
        while (wr_log.size() < 16 && guard < 40) begin tick(); guard++; end
        checks++; if (wr_log.size() != 16) begin
            failures++; $display("[TB] FAIL cont_count got=%0d exp=16", wr_log.size());
        end
        checks++; if (mem_low != 1) begin
            failures++; $display("[TB] FAIL cont_mem_backpressure got=%0d exp=1", mem_low);
        end
        // Expected grant pattern: M M M M A M M M M A, then ALU drains alone.
        for (int i = 0; i < wr_log.size() && i < 16; i++) begin
            if (i < 10 && (i % 5) != 4) e = (exp_mem.size() > 0) ? exp_mem.pop_front() : '1;
            else                        e = (exp_alu.size() > 0) ? exp_alu.pop_front() : '1;
            checks++; if (wr_log[i] !== e) begin
                failures++; $display("[TB] FAIL cont_write i=%0d got=%h exp=%h", i, wr_log[i], e);
            end
        end
        clear_logs();
    endtask

    task automatic test_x0;
        iAluValid = 1'b1; iAluRd = '0; iAluData = 32'h0000_1234;
        @(negedge iClk);
        checks++; if (oAluReady !== 1'b1) begin failures++; $display("[TB] FAIL x0_ready got=%b exp=1", oAluReady); end
        tick();
        iAluValid = 1'b0;
        checks++; if (oAluReady !== 1'b1 || oBusyRd !== '0) begin
            failures++; $display("[TB] FAIL x0_after got=%b/%h exp=1/0", oAluReady, oBusyRd);
        end
        repeat (4) tick();
        checks++; if (wr_log.size() != 0) begin failures++; $display("[TB] FAIL x0_write got=%0d exp=0", wr_log.size()); end
        clear_logs();
    endtask

    task automatic test_collision;
        iAluValid = 1'b1; iAluRd = 5'd7; iAluData = 32'hA;
        iMemValid = 1'b1; iMemRd = 5'd7; iMemData = 32'hB;
        @(negedge iClk);
        checks++; if (oAluReady !== 1'b1 || oMemReady !== 1'b1) begin
            failures++; $display("[TB] FAIL coll_ready got=%b%b exp=11", oAluReady, oMemReady);
        end
        tick();
        exp_alu.push_back({5'd7, 32'hA});
        exp_mem.push_back({5'd7, 32'hB});
        iAluValid = 1'b0; iMemValid = 1'b0;
        checks++; if (oBusyRd !== 32'h80) begin failures++; $display("[TB] FAIL coll_busy0 got=%h exp=80", oBusyRd); end
        tick();
        checks++; if (oBusyRd !== 32'h80) begin failures++; $display("[TB] FAIL coll_busy1 got=%h exp=80", oBusyRd); end
        tick();
        checks++; if (oBusyRd !== '0) begin failures++; $display("[TB] FAIL coll_busy2 got=%h exp=0", oBusyRd); end
        tick();
        checks++; if (wr_log.size() != 2) begin
            failures++; $display("[TB] FAIL coll_count got=%0d exp=2", wr_log.size());
        end else begin
            checks++; if (wr_log[0] !== exp_mem[0]) begin failures++; $display("[TB] FAIL coll_first got=%h exp=%h", wr_log[0], exp_mem[0]); end
            checks++; if (wr_log[1] !== exp_alu[0]) begin failures++; $display("[TB] FAIL coll_second got=%h exp=%h", wr_log[1], exp_alu[0]); end
        end
        clear_logs();
    endtask

    task automatic test_reset_mid;
        iAluValid = 1'b1; iAluRd = 5'd3; iAluData = 32'h3333;
        iMemValid = 1'b1; iMemRd = 5'd20; iMemData = 32'h2020;
        tick();
        iAluRd = 5'd4; iAluData = 32'h4444;
        iMemRd = 5'd21; iMemData = 32'h2121;
        tick();
        iAluValid = 1'b0; iMemValid = 1'b0;
        checks++; if (oBusyRd !== 32'h0020_0018) begin
            failures++; $display("[TB] FAIL mid_busy_pre got=%h exp=00200018", oBusyRd);
        end
        iRst = 1'b0;
        #1;
        checks++; if (oWrEn !== 1'b0 || oBusyRd !== '0) begin
            failures++; $display("[TB] FAIL mid_reset_out got=%b/%h exp=0/0", oWrEn, oBusyRd);
        end
        checks++; if (oAluReady !== 1'b0 || oMemReady !== 1'b0) begin
            failures++; $display("[TB] FAIL mid_reset_ready got=%b%b exp=00", oAluReady, oMemReady);
        end
        wr_log.delete();
        wr_cyc.delete();
        tick();
        @(negedge iClk);
        iRst = 1'b1;
        #1;
        checks++; if (oAluReady !== 1'b0) begin failures++; $display("[TB] FAIL mid_ready_early got=%b exp=0", oAluReady); end
        tick();
        checks++; if (oAluReady !== 1'b1 || oMemReady !== 1'b1) begin
            failures++; $display("[TB] FAIL mid_ready_rel got=%b%b exp=11", oAluReady, oMemReady);
        end
        repeat (5) tick();
        checks++; if (wr_log.size() != 0) begin
            failures++; $display("[TB] FAIL mid_discard got=%0d exp=0", wr_log.size());
        end
        clear_logs();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_contention();
        test_x0();
        test_collision();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
